fsm_seq_checker: RTL and testbench

- Receive-side counterpart of the team's timed state-sequence generator.
- Samples an encoded state stream every valid cycle and checks the expected protocol:
  - Start held for exactly START_CYCLES samples,
  - then One, Two and Three for one sample each,
  - then Finish, which is sticky.
- Flags completion or a sticky, coded error.
- Sits beside a generator FSM as an in-design protocol monitor; it is also used as a bench scoreboard.

---
 rtl/fsm_seq_checker_pkg.sv | 41 ++++
 rtl/fsm_seq_checker_if.sv | 33 +++
 rtl/fsm_seq_checker_sat_counter.sv | 46 ++++
 rtl/fsm_seq_checker.sv | 215 +++++++++++++++++++++
 tb/tb_fsm_seq_checker.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fsm_seq_checker_pkg.sv
// fsm_pkg: shared types for the timed state-sequence generator and its
// receive-side checker.
//   t_state     - encoded protocol state carried on the stream. The generator
//                 reuses it, so the encoding is fixed.
//   t_err_code  - sticky verdict code reported by the checker.
//   t_chk_state - the checker's own FSM states.
//   is_legal_code() - true for the five defined stream codes (0..4).
package fsm_pkg;

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_ONE    = 3'd1,
        ST_TWO    = 3'd2,
        ST_THREE  = 3'd3,
        ST_FINISH = 3'd4
    } t_state;

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_START_LEN    = 3'd1,
        ERR_TRANSITION   = 3'd2,
        ERR_ILLEGAL_CODE = 3'd3,
        ERR_TIMEOUT      = 3'd4
    } t_err_code;

    typedef enum logic [2:0] {
        CHK_IDLE       = 3'd0,
        CHK_CNT_START  = 3'd1,
        CHK_EXP_TWO    = 3'd2,
        CHK_EXP_THREE  = 3'd3,
        CHK_EXP_FINISH = 3'd4,
        CHK_DONE       = 3'd5,
        CHK_ERROR      = 3'd6
    } t_chk_state;

    // Codes 5..7 have no meaning on the stream and are flagged as illegal.
    function automatic logic is_legal_code(input logic [2:0] code);
        return code <= 3'(ST_FINISH);
    endfunction

endpackage

// File: rtl/fsm_seq_checker_if.sv
// fsm_seq_checker_if: stream and verdict signals of the sequence checker.
//   Parameter START_CYCLES sizes out_start_len; it must match the checker.
//   in_valid / in_state / in_restart - driven by the stream source (master)
//   out_busy / out_done / out_err / out_err_code / out_start_len - driven by
//   the checker (slave)
interface fsm_seq_checker_if #(
    parameter int START_CYCLES = 6
);
    localparam int LEN_W = $clog2(START_CYCLES) + 1;

    logic             in_valid;
    logic [2:0]       in_state;
    logic             in_restart;

    logic             out_busy;
    logic             out_done;
    logic             out_err;
    logic [2:0]       out_err_code;
    logic [LEN_W-1:0] out_start_len;

    // The source drives the stream and observes the verdict.
    modport master (
        output in_valid, in_state, in_restart,
        input  out_busy, out_done, out_err, out_err_code, out_start_len
    );

    // The checker observes the stream and drives the verdict.
    modport slave (
        input  in_valid, in_state, in_restart,
        output out_busy, out_done, out_err, out_err_code, out_start_len
    );

endinterface

// File: rtl/fsm_seq_checker_sat_counter.sv
// sat_counter: up-counter that saturates at LIMIT.
//   clk, rst_n - clock and asynchronous active-low reset (count -> 0)
//   clear      - synchronous clear. Together with enable it loads 1, so the
//                first counted event can also restart the count.
//   enable     - count one step. The count holds once it reaches LIMIT.
//   count      - current value
//   sat        - high while count == LIMIT
module sat_counter #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] LIMIT = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             sat
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count. Clear has priority. Clear with enable starts a fresh run
    // at 1. Otherwise the counter steps up until it sticks at LIMIT.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = enable ? WIDTH'(1) : '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign sat   = (count_q == LIMIT);

endmodule

// File: rtl/fsm_seq_checker.sv
// fsm_seq_checker: receive-side protocol monitor for the timed state-sequence
// generator. On each valid sample it expects this order:
//   Start x START_CYCLES, then One, then Two, then Three, then Finish.
//   Finish is sticky.
// The verdict is either a sticky done or a sticky, coded error.
//   theclk   - system clock, rising edge
//   therst_n - asynchronous reset, active low
//   bus      - fsm_seq_checker_if.slave: the stream inputs in_valid,
//              in_state and in_restart, plus the registered verdict outputs
// Optional feature: define FSM_SEQ_CHECKER_TIMEOUT_EN to add a cycle budget
// of TIMEOUT clocks from the first Start sample to Finish. Running out of
// budget gives error code 4. Without the macro, TIMEOUT has no effect.
module fsm_seq_checker
    import fsm_pkg::*;
#(
    parameter int START_CYCLES = 6,
    parameter int TIMEOUT      = 32
) (
    input logic              theclk,
    input logic              therst_n,
    fsm_seq_checker_if.slave bus
);

    localparam int               LEN_W        = $clog2(START_CYCLES) + 1;
    localparam logic [LEN_W-1:0] START_TARGET = LEN_W'(START_CYCLES);

    t_chk_state       state_q, state_d;
    t_err_code        err_code_q, err_code_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [LEN_W-1:0] start_len;
    logic             start_len_sat_unused;
    logic             sample_start;
    logic             first_start;
    logic             len_clear;
    logic             len_enable;
    logic             timeout_hit;

    // A restart discards the sample taken with it, so a Start that arrives
    // together with in_restart must not reach either counter.
    always_comb begin
        sample_start = bus.in_valid && !bus.in_restart
                       && (bus.in_state == 3'(ST_START));
        first_start  = sample_start && (state_q == CHK_IDLE);
        len_clear    = bus.in_restart || first_start;
        len_enable   = sample_start
                       && ((state_q == CHK_IDLE) || (state_q == CHK_CNT_START));
    end

    // Start-run length. It is frozen once CntStart is left, because only
    // Start samples in Idle or CntStart enable it.
    sat_counter #(
        .WIDTH (LEN_W)
    ) u_start_len (
        .clk    (theclk),
        .rst_n  (therst_n),
        .clear  (len_clear),
        .enable (len_enable),
        .count  (start_len),
        .sat    (start_len_sat_unused)
    );

`ifdef FSM_SEQ_CHECKER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT) + 1;

    logic [TO_W-1:0] timeout_count_unused;
    logic            to_clear;
    logic            to_enable;

    // The budget starts at 1 on the edge that takes the first Start sample.
    // After that it ticks every clock while busy, valid or not. A restart
    // only clears the count.
    always_comb begin
        to_clear  = bus.in_restart || first_start;
        to_enable = !bus.in_restart && (first_start || busy_q);
    end

    sat_counter #(
        .WIDTH (TO_W),
        .LIMIT (TO_W'(TIMEOUT))
    ) u_timeout (
        .clk    (theclk),
        .rst_n  (therst_n),
        .clear  (to_clear),
        .enable (to_enable),
        .count  (timeout_count_unused),
        .sat    (timeout_hit)
    );
`else
    localparam int timeout_unused = TIMEOUT;

    assign timeout_hit = 1'b0;
`endif

    // Next-state logic. Restart beats everything else. Error is terminal, so
    // the first error code is never overwritten. An illegal code is checked
    // before the per-state rules. The timeout applies only when the sample
    // itself does not complete or fail the run, so Finish on the expiry
    // cycle still wins.
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        if (bus.in_restart) begin
            state_d    = CHK_IDLE;
            err_code_d = ERR_NONE;
        end else begin
            if (bus.in_valid && (state_q != CHK_ERROR)) begin
                if (!is_legal_code(bus.in_state)) begin
                    state_d    = CHK_ERROR;
                    err_code_d = ERR_ILLEGAL_CODE;
                end else begin
                    case (state_q)
                        CHK_IDLE: begin
                            if (bus.in_state == 3'(ST_START)) begin
                                state_d = CHK_CNT_START;
                            end else begin
                                state_d    = CHK_ERROR;
                                err_code_d = ERR_TRANSITION;
                            end
                        end
                        CHK_CNT_START: begin
                            if (bus.in_state == 3'(ST_START)) begin
                                state_d = CHK_CNT_START;
                            end else if (bus.in_state == 3'(ST_ONE)) begin
                                if (start_len == START_TARGET) begin
                                    state_d = CHK_EXP_TWO;
                                end else begin
                                    state_d    = CHK_ERROR;
                                    err_code_d = ERR_START_LEN;
                                end
                            end else begin
                                state_d    = CHK_ERROR;
                                err_code_d = ERR_TRANSITION;
                            end
                        end
                        CHK_EXP_TWO: begin
                            if (bus.in_state == 3'(ST_TWO)) begin
                                state_d = CHK_EXP_THREE;
                            end else begin
                                state_d    = CHK_ERROR;
                                err_code_d = ERR_TRANSITION;
                            end
                        end
                        CHK_EXP_THREE: begin
                            if (bus.in_state == 3'(ST_THREE)) begin
                                state_d = CHK_EXP_FINISH;
                            end else begin
                                state_d    = CHK_ERROR;
                                err_code_d = ERR_TRANSITION;
                            end
                        end
                        CHK_EXP_FINISH: begin
                            if (bus.in_state == 3'(ST_FINISH)) begin
                                state_d = CHK_DONE;
                            end else begin
                                state_d    = CHK_ERROR;
                                err_code_d = ERR_TRANSITION;
                            end
                        end
                        CHK_DONE: begin
                            if (bus.in_state != 3'(ST_FINISH)) begin
                                state_d    = CHK_ERROR;
                                err_code_d = ERR_TRANSITION;
                            end
                        end
                        default: begin
                            state_d = state_q;
                        end
                    endcase
                end
            end
            if (timeout_hit && busy_q
                && (state_d != CHK_DONE) && (state_d != CHK_ERROR)) begin
                state_d    = CHK_ERROR;
                err_code_d = ERR_TIMEOUT;
            end
        end
    end

    // The flag outputs are decoded from the next state so that they leave
    // the flops together with the state they describe.
    always_comb begin
        busy_d = state_d inside {CHK_CNT_START, CHK_EXP_TWO,
                                 CHK_EXP_THREE, CHK_EXP_FINISH};
        done_d = (state_d == CHK_DONE);
        err_d  = (state_d == CHK_ERROR);
    end

    // State and verdict registers. Reset aborts the run immediately, with
    // no partial verdict.
    always_ff @(posedge theclk or negedge therst_n) begin
        if (!therst_n) begin
            state_q    <= CHK_IDLE;
            err_code_q <= ERR_NONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.out_busy      = busy_q;
    assign bus.out_done      = done_q;
    assign bus.out_err       = err_q;
    assign bus.out_err_code  = err_code_q;
    assign bus.out_start_len = start_len;

endmodule

// File: tb/tb_fsm_seq_checker.sv
// tb_fsm_seq_checker: self-checking bench for fsm_seq_checker.
// A table of {stimulus, expected verdict} records covers the single-sample
// rules. Hand-written sequences cover gaps, saturation, asynchronous reset
// in the middle of a run and, when FSM_SEQ_CHECKER_TIMEOUT_EN is defined,
// the timeout budget.
module tb_fsm_seq_checker;
    import fsm_pkg::*;

    localparam int START_CYCLES = 6;
    localparam int TIMEOUT      = 16;
    localparam int LEN_W        = $clog2(START_CYCLES) + 1;

    typedef struct {
        logic             valid;
        logic [2:0]       st;
        logic             restart;
        logic             busy;
        logic             done;
        logic             err;
        logic [2:0]       code;
        logic [LEN_W-1:0] len;
    } vec_t;

    logic theclk;
    logic therst_n;
    int   checks;
    int   errors;
    vec_t vecs[$];

    fsm_seq_checker_if #(.START_CYCLES(START_CYCLES)) bus ();

    fsm_seq_checker #(
        .START_CYCLES (START_CYCLES),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .theclk   (theclk),
        .therst_n (therst_n),
        .bus      (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        theclk = 1'b0;
        forever #5 theclk = ~theclk;
    end

    // Drive one input sample at a falling edge and return at the next falling
    // edge, when the registered verdict for that sample is visible.
    task automatic applyStimulus(input logic v, input logic [2:0] s, input logic r);
        bus.in_valid   = v;
        bus.in_state   = s;
        bus.in_restart = r;
        @(posedge theclk);
        @(negedge theclk);
    endtask

    // Compare every output against the expected verdict as one check.
    task automatic checkOutput(input string name, input logic busy, input logic done,
                               input logic err, input logic [2:0] code,
                               input logic [LEN_W-1:0] len);
        checks++;
        if (bus.out_busy !== busy || bus.out_done !== done || bus.out_err !== err ||
            bus.out_err_code !== code || bus.out_start_len !== len) begin
            errors++;
            $display("[TB] FAIL %s: busy/done/err/code/len got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                     name, bus.out_busy, bus.out_done, bus.out_err, bus.out_err_code,
                     bus.out_start_len, busy, done, err, code, len);
        end
    endtask

    // Append one record to the vector table.
    task automatic addVec(input logic v, input logic [2:0] s, input logic r,
                          input logic busy, input logic done, input logic err,
                          input logic [2:0] code, input int len);
        vec_t t;
        t.valid   = v;
        t.st      = s;
        t.restart = r;
        t.busy    = busy;
        t.done    = done;
        t.err     = err;
        t.code    = code;
        t.len     = LEN_W'(len);
        vecs.push_back(t);
    endtask

    // Run the complete legal sequence, then check for done.
    task automatic runNominal(input string name);
        for (int i = 0; i < START_CYCLES; i++) applyStimulus(1'b1, ST_START, 1'b0);
        applyStimulus(1'b1, ST_ONE, 1'b0);
        applyStimulus(1'b1, ST_TWO, 1'b0);
        applyStimulus(1'b1, ST_THREE, 1'b0);
        applyStimulus(1'b1, ST_FINISH, 1'b0);
        checkOutput(name, 1'b0, 1'b1, 1'b0, 3'd0, LEN_W'(START_CYCLES));
    endtask

    // Main stimulus. Fill the table, reset, replay the table, then run the
    // multi-cycle sequences.
    initial begin
        logic [2:0] seq [10];
        checks = 0;
        errors = 0;

        // Nominal run, repeated Finish, an ignored gap in Done, then restart.
        for (int i = 1; i <= 6; i++) addVec(1, ST_START, 0, 1, 0, 0, 0, i);
        addVec(1, ST_ONE,    0, 1, 0, 0, 0, 6);
        addVec(1, ST_TWO,    0, 1, 0, 0, 0, 6);
        addVec(1, ST_THREE,  0, 1, 0, 0, 0, 6);
        addVec(1, ST_FINISH, 0, 0, 1, 0, 0, 6);
        addVec(1, ST_FINISH, 0, 0, 1, 0, 0, 6);
        addVec(0, ST_ONE,    0, 0, 1, 0, 0, 6);
        addVec(1, ST_START,  1, 0, 0, 0, 0, 0);
        // Short Start run; the first code sticks.
        for (int i = 1; i <= 5; i++) addVec(1, ST_START, 0, 1, 0, 0, 0, i);
        addVec(1, ST_ONE,   0, 0, 0, 1, 1, 5);
        addVec(1, ST_TWO,   0, 0, 0, 1, 1, 5);
        addVec(1, 3'd7,     0, 0, 0, 1, 1, 5);
        addVec(0, ST_START, 1, 0, 0, 0, 0, 0);
        // Illegal code in ExpThree, then restart with a valid Start.
        for (int i = 1; i <= 6; i++) addVec(1, ST_START, 0, 1, 0, 0, 0, i);
        addVec(1, ST_ONE,   0, 1, 0, 0, 0, 6);
        addVec(1, ST_TWO,   0, 1, 0, 0, 0, 6);
        addVec(1, 3'd6,     0, 0, 0, 1, 3, 6);
        addVec(1, ST_START, 1, 0, 0, 0, 0, 0);
        // Wrong first sample in Idle: a legal code, then an illegal one.
        addVec(1, ST_TWO,   0, 0, 0, 1, 2, 0);
        addVec(0, ST_START, 1, 0, 0, 0, 0, 0);
        addVec(1, 3'd5,     0, 0, 0, 1, 3, 0);
        addVec(0, ST_START, 1, 0, 0, 0, 0, 0);
        // Leaving Done on a non-Finish sample clears done.
        for (int i = 1; i <= 6; i++) addVec(1, ST_START, 0, 1, 0, 0, 0, i);
        addVec(1, ST_ONE,    0, 1, 0, 0, 0, 6);
        addVec(1, ST_TWO,    0, 1, 0, 0, 0, 6);
        addVec(1, ST_THREE,  0, 1, 0, 0, 0, 6);
        addVec(1, ST_FINISH, 0, 0, 1, 0, 0, 6);
        addVec(1, ST_TWO,    0, 0, 0, 1, 2, 6);
        addVec(0, ST_START,  1, 0, 0, 0, 0, 0);
        // Wrong transition out of CntStart.
        addVec(1, ST_START, 0, 1, 0, 0, 0, 1);
        addVec(1, ST_TWO,   0, 0, 0, 1, 2, 1);
        addVec(0, ST_START, 1, 0, 0, 0, 0, 0);
        // Start run one sample too long.
        for (int i = 1; i <= 7; i++) addVec(1, ST_START, 0, 1, 0, 0, 0, i);
        addVec(1, ST_ONE,   0, 0, 0, 1, 1, 7);
        addVec(0, ST_START, 1, 0, 0, 0, 0, 0);

        // Reset held for 4 cycles.
        therst_n       = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_state   = 3'd0;
        bus.in_restart = 1'b0;
        repeat (4) @(negedge theclk);
        checkOutput("reset_state", 1'b0, 1'b0, 1'b0, 3'd0, '0);
        therst_n = 1'b1;

        $display("[TB] applying %0d table vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].valid, vecs[i].st, vecs[i].restart);
            checkOutput($sformatf("vec[%0d]", i), vecs[i].busy, vecs[i].done,
                        vecs[i].err, vecs[i].code, vecs[i].len);
        end

        // Nominal run with 3-cycle invalid gaps, which carry junk codes.
        seq = '{ST_START, ST_START, ST_START, ST_START, ST_START, ST_START,
                ST_ONE, ST_TWO, ST_THREE, ST_FINISH};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, seq[i], 1'b0);
            repeat (3) applyStimulus(1'b0, 3'd7, 1'b0);
            if (i == 2) checkOutput("gap_hold", 1'b1, 1'b0, 1'b0, 3'd0, LEN_W'(3));
        end
        checkOutput("gap_done", 1'b0, 1'b1, 1'b0, 3'd0, LEN_W'(6));

        // A repeated One is a transition error.
        applyStimulus(1'b0, ST_START, 1'b1);
        for (int i = 0; i < START_CYCLES; i++) applyStimulus(1'b1, ST_START, 1'b0);
        applyStimulus(1'b1, ST_ONE, 1'b0);
        checkOutput("one_accepted", 1'b1, 1'b0, 1'b0, 3'd0, LEN_W'(6));
        applyStimulus(1'b1, ST_ONE, 1'b0);
        checkOutput("repeat_one", 1'b0, 1'b0, 1'b1, 3'd2, LEN_W'(6));

        // start_len saturates at all-ones, and One is then a length error.
        applyStimulus(1'b0, ST_START, 1'b1);
        repeat (16) applyStimulus(1'b1, ST_START, 1'b0);
        checkOutput("len_saturated", 1'b1, 1'b0, 1'b0, 3'd0, '1);
        applyStimulus(1'b1, ST_ONE, 1'b0);
        checkOutput("len_sat_one", 1'b0, 1'b0, 1'b1, 3'd1, '1);

        // Asynchronous reset in CntStart clears outputs before the next edge.
        applyStimulus(1'b0, ST_START, 1'b1);
        repeat (3) applyStimulus(1'b1, ST_START, 1'b0);
        checkOutput("pre_reset", 1'b1, 1'b0, 1'b0, 3'd0, LEN_W'(3));
        #2 therst_n = 1'b0;
        #1 checkOutput("async_reset", 1'b0, 1'b0, 1'b0, 3'd0, '0);
        @(negedge theclk);
        bus.in_valid = 1'b0;
        @(negedge theclk);
        therst_n = 1'b1;
        runNominal("replay_after_reset");

`ifdef FSM_SEQ_CHECKER_TIMEOUT_EN
        // Start x6 and then silence: the budget runs out 16 edges after the
        // first Start edge.
        applyStimulus(1'b0, ST_START, 1'b1);
        for (int i = 0; i < START_CYCLES; i++) applyStimulus(1'b1, ST_START, 1'b0);
        repeat (TIMEOUT - START_CYCLES) applyStimulus(1'b0, ST_START, 1'b0);
        checkOutput("timeout_pending", 1'b1, 1'b0, 1'b0, 3'd0, LEN_W'(6));
        applyStimulus(1'b0, ST_START, 1'b0);
        checkOutput("timeout_fired", 1'b0, 1'b0, 1'b1, 3'd4, LEN_W'(6));

        // Finish on the expiry edge wins over the timeout.
        applyStimulus(1'b0, ST_START, 1'b1);
        for (int i = 0; i < START_CYCLES; i++) applyStimulus(1'b1, ST_START, 1'b0);
        applyStimulus(1'b1, ST_ONE, 1'b0);
        applyStimulus(1'b1, ST_TWO, 1'b0);
        applyStimulus(1'b1, ST_THREE, 1'b0);
        repeat (TIMEOUT - START_CYCLES - 3) applyStimulus(1'b0, ST_START, 1'b0);
        checkOutput("expiry_pending", 1'b1, 1'b0, 1'b0, 3'd0, LEN_W'(6));
        applyStimulus(1'b1, ST_FINISH, 1'b0);
        checkOutput("finish_on_expiry", 1'b0, 1'b1, 1'b0, 3'd0, LEN_W'(6));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
